barrier_gate_ctrl: RTL and testbench
====================================

# barrier_gate_ctrl

Entry-barrier controller for the car park. It sits directly downstream of the car counter and consumes the occupancy count and the carIn pulse from the sensor FSM. It opens the entry gate on a debounced driver request only while the park is not full, closes it after the car has entered or after a timeout, and signals a denial when the park is full.

## Interface
- CAPACITY, default 7: occupancy at or above which entry is denied.
- MOVE_CYCLES, default 25_000_000: clock cycles for a full open or close motor stroke.
- OPEN_TIMEOUT, default 250_000_000: maximum cycles the gate stays open without a carIn pulse.
- DENY_CYCLES, default 50_000_000: cycles the deny indicator is held.
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  1  debounced entry-request level, active-high. Edge-detected internally.
- count  input  3  current occupancy from the car counter.
- carIn  input  1  single-cycle pulse from the sensor FSM marking a completed car entry.
- motor_up  output  1  drive barrier upward.
- motor_down  output  1  drive barrier downward.
- gate_open  output  1  barrier fully open.
- full  output  1  registered flag, `count >= CAPACITY`.
- deny_led  output  1  entry-refused indicator.

## Operation
- **State register:** CLOSED, OPENING, OPEN, CLOSING, DENY. Reset state is CLOSED.
- **Timer:** one free-running up-counter, `$clog2` of the largest parameter wide. It clears to 0 on every state change unless a reload value is given below.
- **Request edge:** `req_edge = req & ~req_prev`. `req_prev` resets to 1, so a request held through reset never fires.
- **full:** register updated every cycle from `count >= CAPACITY`. It lags count by one cycle.
- **Outputs:** Moore-decoded from the state register only.
  - motor_up = OPENING
  - motor_down = CLOSING
  - gate_open = OPEN
  - deny_led = DENY
  - motor_up and motor_down are never high together.
- **Transitions (per-state priority as listed):**
  - CLOSED:
    - req_edge & full -> DENY.
    - req_edge & ~full -> OPENING.
  - OPENING: timer == MOVE_CYCLES-1 -> OPEN. req_edge and carIn are ignored.
  - OPEN:
    - carIn -> CLOSING.
    - Otherwise, timer == OPEN_TIMEOUT-1 -> CLOSING.
    - req_edge is ignored.
  - CLOSING:
    - req_edge & ~full -> OPENING, with the timer reloaded to `MOVE_CYCLES-1-timer`. This reverses the stroke from the current position.
    - Otherwise, timer == MOVE_CYCLES-1 -> CLOSED.
  - DENY: timer == DENY_CYCLES-1 -> CLOSED. All inputs are ignored.
- carIn outside OPEN is ignored. Count bookkeeping belongs to the counter, not this block.
- Synchronous active-low reset at any cycle forces:
  - state CLOSED, timer 0, req_prev 1;
  - every output 0 on the next edge, including any motor drive mid-stroke.

## Timing
- Every output is 0 from the first edge with reset low until the first state change after reset is released.
- req_edge sampled at edge k: motor_up or deny_led is high from edge k+1.
- OPENING lasts exactly MOVE_CYCLES cycles, then gate_open rises.
- carIn sampled in OPEN at edge k: gate_open falls and motor_down rises at edge k+1.
- An untouched OPEN lasts exactly OPEN_TIMEOUT cycles.
- CLOSING lasts MOVE_CYCLES cycles. DENY lasts DENY_CYCLES cycles.
- CLOSING reversal after e cycles in CLOSING (timer = e-1): the following OPENING lasts e cycles.
- **Boundary case:** if count reaches CAPACITY in the same cycle as req_edge, the stale full=0 is used and the gate opens. The next request is denied.
- Every parameter must be ≥ 1. MOVE_CYCLES=1 gives one-cycle strokes.

## Test plan
Bench parameters: CAPACITY=7, MOVE_CYCLES=4, OPEN_TIMEOUT=10, DENY_CYCLES=3.

1. **Normal entry:** count=3, req pulse held 5 cycles, carIn at 2nd OPEN cycle -> motor_up 4 cycles, gate_open 2 cycles, motor_down 4 cycles, then idle. Only one opening despite req held.
2. **Full:** count=7, req edge -> full=1, deny_led high exactly 3 cycles, motors never asserted. A second req edge during DENY is ignored.
3. **Timeout:** count=0, req edge, no carIn -> gate_open high exactly 10 cycles, then motor_down 4 cycles, back to CLOSED.
4. **Reversal:** req edge in 2nd CLOSING cycle with count=2 -> motor_up for exactly 2 cycles, then gate_open.
5. **Reset mid-stroke:** reset low in 3rd OPENING cycle with req held high -> all outputs 0 next edge. After release with req still high, the block stays CLOSED until req falls and rises again.
6. **Edge of capacity:** count steps 6->7 in the same cycle as req_edge -> gate opens. After close, a new req edge -> DENY.

Source files
------------

// File: rtl/barrier_gate_ctrl_if.sv
// Entry-barrier signal bundle: request/occupancy/carIn in, motor/indicator flags out.
// The block drives the slave side; the surrounding logic or bench drives the master side.
interface barrier_gate_ctrl_if;
    logic       req;
    logic [2:0] count;
    logic       carIn;
    logic       motor_up;
    logic       motor_down;
    logic       gate_open;
    logic       full;
    logic       deny_led;

    modport master (
        output req, count, carIn,
        input  motor_up, motor_down, gate_open, full, deny_led
    );

    modport slave (
        input  req, count, carIn,
        output motor_up, motor_down, gate_open, full, deny_led
    );
endinterface

// File: rtl/barrier_gate_ctrl.sv
// Car-park entry barrier: opens on a request edge while not full, closes on carIn or timeout.
// Outputs are Moore-decoded and react one edge after the causing input; there is no backpressure.
module barrier_gate_ctrl #(
    parameter int unsigned CAPACITY     = 7,
    parameter int unsigned MOVE_CYCLES  = 25_000_000,
    parameter int unsigned OPEN_TIMEOUT = 250_000_000,
    parameter int unsigned DENY_CYCLES  = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    barrier_gate_ctrl_if.slave  gate
);

    localparam int unsigned MAX_MO = (MOVE_CYCLES > OPEN_TIMEOUT) ? MOVE_CYCLES : OPEN_TIMEOUT;
    localparam int unsigned MAX_P  = (MAX_MO > DENY_CYCLES) ? MAX_MO : DENY_CYCLES;
    localparam int unsigned TW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] OPEN_LAST = TW'(OPEN_TIMEOUT - 1);
    localparam logic [TW-1:0] DENY_LAST = TW'(DENY_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING,
        ST_DENY
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          req_prev_q;
    logic          full_q, full_d;
    logic          req_edge;
    logic          reverse;

    assign req_edge = gate.req & ~req_prev_q;
    assign full_d   = ({29'd0, gate.count} >= CAPACITY);

    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 1'b1;
        reverse = 1'b0;
        case (state_q)
            ST_CLOSED: begin
                if (req_edge) begin
                    state_d = full_q ? ST_DENY : ST_OPENING;
                end
            end
            ST_OPENING: begin
                if (timer_q == MOVE_LAST) begin
                    state_d = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (gate.carIn || (timer_q == OPEN_LAST)) begin
                    state_d = ST_CLOSING;
                end
            end
            ST_CLOSING: begin
                if (req_edge && !full_q) begin
                    state_d = ST_OPENING;
                    reverse = 1'b1;
                end else if (timer_q == MOVE_LAST) begin
                    state_d = ST_CLOSED;
                end
            end
            ST_DENY: begin
                if (timer_q == DENY_LAST) begin
                    state_d = ST_CLOSED;
                end
            end
            default: begin
                state_d = ST_CLOSED;
            end
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end
        // Reopening from part-way down: start the up-stroke at the mirrored position.
        if (reverse) begin
            timer_d = MOVE_LAST - timer_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_CLOSED;
            timer_q    <= '0;
            req_prev_q <= 1'b1;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            req_prev_q <= gate.req;
            full_q     <= full_d;
        end
    end

    assign gate.motor_up   = (state_q == ST_OPENING);
    assign gate.motor_down = (state_q == ST_CLOSING);
    assign gate.gate_open  = (state_q == ST_OPEN);
    assign gate.deny_led   = (state_q == ST_DENY);
    assign gate.full       = full_q;

endmodule

// File: tb/tb_barrier_gate_ctrl.sv
// Bench for barrier_gate_ctrl: directed scenarios plus random traffic against a phase/countdown model.
module tb_barrier_gate_ctrl;

    localparam int CAP = 7;
    localparam int MV  = 4;
    localparam int TO  = 10;
    localparam int DN  = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    barrier_gate_ctrl_if gif ();

    barrier_gate_ctrl #(
        .CAPACITY    (CAP),
        .MOVE_CYCLES (MV),
        .OPEN_TIMEOUT(TO),
        .DENY_CYCLES (DN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .gate (gif.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef enum int {M_IDLE, M_RAISE, M_UP, M_LOWER, M_REFUSE} mphase_t;
    mphase_t ph      = M_IDLE;
    int      left    = 0;
    bit      m_prev  = 1'b1;
    bit      m_full  = 1'b0;
    bit      m_live  = 1'b0;

    int cnt_up = 0, cnt_open = 0, cnt_down = 0, cnt_deny = 0, rises_up = 0;
    bit last_up = 1'b0;

    // Model: each timed phase holds a count of cycles still to run.
    always @(posedge clk) begin
        bit rq_edge;
        if (!reset) begin
            ph     = M_IDLE;
            left   = 0;
            m_prev = 1'b1;
            m_full = 1'b0;
            m_live = 1'b1;
        end else begin
            rq_edge = gif.req && !m_prev;
            case (ph)
                M_IDLE: begin
                    if (rq_edge) begin
                        if (m_full) begin ph = M_REFUSE; left = DN; end
                        else        begin ph = M_RAISE;  left = MV; end
                    end
                end
                M_RAISE: begin
                    left--;
                    if (left == 0) begin ph = M_UP; left = TO; end
                end
                M_UP: begin
                    if (gif.carIn) begin
                        ph = M_LOWER; left = MV;
                    end else begin
                        left--;
                        if (left == 0) begin ph = M_LOWER; left = MV; end
                    end
                end
                M_LOWER: begin
                    if (rq_edge && !m_full) begin
                        left = MV - left + 1;
                        ph   = M_RAISE;
                    end else begin
                        left--;
                        if (left == 0) ph = M_IDLE;
                    end
                end
                M_REFUSE: begin
                    left--;
                    if (left == 0) ph = M_IDLE;
                end
                default: ph = M_IDLE;
            endcase
            m_prev = gif.req;
            m_full = (int'(gif.count) >= CAP);
        end
        #1;
        if (m_live) begin
            vectors++;
            if (gif.motor_up   !== (ph == M_RAISE) ||
                gif.motor_down !== (ph == M_LOWER) ||
                gif.gate_open  !== (ph == M_UP)    ||
                gif.deny_led   !== (ph == M_REFUSE) ||
                gif.full       !== m_full) begin
                miscompares++;
                $display("FAIL cycle_outputs t=%0t up/down/open/deny/full got %b%b%b%b%b want %b%b%b%b%b",
                         $time, gif.motor_up, gif.motor_down, gif.gate_open, gif.deny_led, gif.full,
                         ph == M_RAISE, ph == M_LOWER, ph == M_UP, ph == M_REFUSE, m_full);
            end
            if (gif.motor_up === 1'b1)   cnt_up++;
            if (gif.gate_open === 1'b1)  cnt_open++;
            if (gif.motor_down === 1'b1) cnt_down++;
            if (gif.deny_led === 1'b1)   cnt_deny++;
            if (gif.motor_up === 1'b1 && !last_up) rises_up++;
            last_up = (gif.motor_up === 1'b1);
        end
    end

    int b_up, b_open, b_down, b_deny, b_rise;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        b_up = cnt_up; b_open = cnt_open; b_down = cnt_down; b_deny = cnt_deny; b_rise = rises_up;
    endtask

    task automatic lit(input string nm, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic lit_counts(input string tag, input int up, input int opn, input int dn, input int dny);
        lit({tag, "_up"},   cnt_up   - b_up,   up);
        lit({tag, "_open"}, cnt_open - b_open, opn);
        lit({tag, "_down"}, cnt_down - b_down, dn);
        lit({tag, "_deny"}, cnt_deny - b_deny, dny);
    endtask

    initial begin
        reset     = 1'b0;
        gif.req   = 1'b1;
        gif.count = 3'd0;
        gif.carIn = 1'b0;
        tick(3);
        lit("reset_outputs",
            int'({gif.motor_up, gif.motor_down, gif.gate_open, gif.full, gif.deny_led}), 0);

        // Request held through reset must not open the gate.
        snap();
        reset = 1'b1;
        tick(6);
        lit_counts("held_req", 0, 0, 0, 0);

        // Normal entry
        gif.req = 1'b0; gif.count = 3'd3; tick(2);
        snap();
        gif.req = 1'b1; tick(5);
        gif.req = 1'b0; tick(1);
        gif.carIn = 1'b1; tick(1);
        gif.carIn = 1'b0; tick(15);
        lit_counts("normal", 4, 2, 4, 0);
        lit("normal_rises", rises_up - b_rise, 1);

        // Full: deny, second edge inside DENY ignored
        gif.count = 3'd7; tick(3);
        snap();
        gif.req = 1'b1; tick(1);
        gif.req = 1'b0; tick(1);
        gif.req = 1'b1; tick(10);
        lit_counts("full", 0, 0, 0, 3);
        lit("full_flag", int'(gif.full), 1);
        gif.req = 1'b0;

        // Timeout
        gif.count = 3'd0; tick(3);
        snap();
        gif.req = 1'b1; tick(2);
        gif.req = 1'b0; tick(25);
        lit_counts("timeout", 4, 10, 4, 0);

        // Reversal in the second closing cycle
        gif.count = 3'd2; tick(3);
        snap();
        gif.req = 1'b1; tick(2);
        gif.req = 1'b0; tick(3);
        gif.carIn = 1'b1; tick(1);
        gif.carIn = 1'b0; tick(1);
        gif.req = 1'b1; tick(1);
        gif.req = 1'b0; tick(25);
        lit_counts("reversal", 6, 11, 6, 0);
        lit("reversal_rises", rises_up - b_rise, 2);

        // Reset mid-stroke with request held
        gif.count = 3'd1; tick(3);
        snap();
        gif.req = 1'b1; tick(3);
        reset = 1'b0; tick(2);
        lit_counts("rst_mid", 3, 0, 0, 0);
        reset = 1'b1;
        snap();
        tick(10);
        lit_counts("rst_release", 0, 0, 0, 0);
        gif.req = 1'b0; tick(2);
        snap();
        gif.req = 1'b1; tick(1);
        gif.req = 1'b0; tick(25);
        lit_counts("rst_reopen", 4, 10, 4, 0);

        // Capacity reached in the same cycle as the request
        gif.count = 3'd6; tick(3);
        snap();
        gif.count = 3'd7; gif.req = 1'b1; tick(2);
        gif.req = 1'b0; tick(3);
        gif.carIn = 1'b1; tick(1);
        gif.carIn = 1'b0; tick(10);
        lit_counts("cap_edge_open", 4, 1, 4, 0);
        snap();
        gif.req = 1'b1; tick(1);
        gif.req = 1'b0; tick(8);
        lit_counts("cap_edge_deny", 0, 0, 0, 3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0)  gif.req   = ~gif.req;
            if ($urandom_range(7) == 0)  gif.count = 3'($urandom_range(7));
            gif.carIn = ($urandom_range(5) == 0);
            reset     = ($urandom_range(99) != 0);
        end
        reset = 1'b1;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
